// File: rtl/datamem_arbiter_pkg.sv
// Shared types for the two-requester data memory arbiter: FSM states,
// access size codes and the size-to-byte-count helper.
package datamem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // One bit wider than an address so the end-of-access sum cannot wrap.
  function automatic logic [32:0] sizeBytes(input logic [1:0] size);
    case (size)
      SZ_WORD: sizeBytes = 33'd4;
      SZ_HALF: sizeBytes = 33'd2;
      SZ_BYTE: sizeBytes = 33'd1;
      default: sizeBytes = 33'd0;
    endcase
  endfunction

endpackage

// File: rtl/datamem_arbiter_addr_check.sv
// Combinational legality check of a request: size code, natural alignment
// and containment of every accessed byte inside [STARTADDR, STARTADDR+LENGTH).
module datamem_addr_check
  import datamem_arbiter_pkg::*;
#(
  parameter logic [31:0] STARTADDR = 32'h1000_0000,
  parameter logic [31:0] LENGTH    = 32'h0000_1000
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  logic        misalign_s;
  logic        outOfRange_s;
  logic [32:0] endAddr_s;
  logic [32:0] limit_s;

  // Alignment rule per size; the illegal code is always rejected.
  always_comb begin
    misalign_s = 1'b0;
    case (size)
      SZ_WORD: misalign_s = (addr[1:0] != 2'b00);
      SZ_HALF: misalign_s = addr[0];
      SZ_BYTE: misalign_s = 1'b0;
      default: misalign_s = 1'b1;
    endcase
  end

  assign endAddr_s    = {1'b0, addr} + sizeBytes(size);
  assign limit_s      = {1'b0, STARTADDR} + {1'b0, LENGTH};
  assign outOfRange_s = (addr < STARTADDR) || (endAddr_s > limit_s);
  assign err          = misalign_s | outOfRange_s;

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter giving two requesters access to a single-port data
// memory; each access walks IDLE -> ACCESS -> RESP.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter logic [31:0] STARTADDR = 32'h1000_0000,
  parameter logic [31:0] LENGTH    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_size,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_size,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  output logic        mem_writebyte,
  output logic        mem_writehalfword,
  input  logic [31:0] mem_data,
  output logic        busy
);

  arbState_t   state_r;
  arbState_t   nextState_s;
  logic        lastServed_r;
  logic        selId_r;
  logic        we_r;
  logic        err_r;
  logic        grant1_s;
  logic        start_s;
  logic [31:0] selAddr_s;
  logic [31:0] selWdata_s;
  logic [1:0]  selSize_s;
  logic        selWe_s;
  logic        selErr_s;

  // Requester 1 wins when alone, or in contention when requester 0 went last.
  assign grant1_s = r1_req & (~r0_req | ~lastServed_r);
  assign start_s  = (state_r == IDLE) && (r0_req || r1_req);

  // Mux the granted requester's command toward the latch and checker.
  always_comb begin
    if (grant1_s) begin
      selAddr_s  = r1_addr;
      selWdata_s = r1_wdata;
      selSize_s  = r1_size;
      selWe_s    = r1_we;
    end else begin
      selAddr_s  = r0_addr;
      selWdata_s = r0_wdata;
      selSize_s  = r0_size;
      selWe_s    = r0_we;
    end
  end

  datamem_addr_check #(
    .STARTADDR (STARTADDR),
    .LENGTH    (LENGTH)
  ) u_addrCheck (
    .addr (selAddr_s),
    .size (selSize_s),
    .err  (selErr_s)
  );

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          nextState_s = ACCESS;
        end else begin
          nextState_s = IDLE;
        end
      end
      ACCESS:  nextState_s = RESP;
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register, busy flag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy         <= 1'b0;
      lastServed_r <= 1'b1;
    end else begin
      state_r <= nextState_s;
      busy    <= (nextState_s != IDLE);
      if (state_r == RESP) begin
        lastServed_r <= selId_r;
      end
    end
  end

  // Command latch; mem_address/mem_datain double as the latched address/data
  // and keep their value after the access, while write strobes live only in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selId_r           <= 1'b0;
      we_r              <= 1'b0;
      err_r             <= 1'b0;
      mem_address       <= 32'h0;
      mem_datain        <= 32'h0;
      mem_we            <= 1'b0;
      mem_writebyte     <= 1'b0;
      mem_writehalfword <= 1'b0;
    end else if (start_s) begin
      selId_r           <= grant1_s;
      we_r              <= selWe_s;
      err_r             <= selErr_s;
      mem_address       <= selAddr_s;
      mem_datain        <= selWdata_s;
      mem_we            <= selWe_s & ~selErr_s;
      mem_writebyte     <= (selSize_s == SZ_BYTE);
      mem_writehalfword <= (selSize_s == SZ_HALF);
    end else begin
      mem_we            <= 1'b0;
      mem_writebyte     <= 1'b0;
      mem_writehalfword <= 1'b0;
    end
  end

  // Response: one-cycle ack/err in RESP and load data capture on ACCESS exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
      r0_rdata <= 32'h0;
      r1_rdata <= 32'h0;
    end else if (state_r == ACCESS) begin
      r0_ack <= ~selId_r;
      r1_ack <= selId_r;
      r0_err <= ~selId_r & err_r;
      r1_err <= selId_r & err_r;
      if (!we_r && !err_r) begin
        if (selId_r) begin
          r1_rdata <= mem_data;
        end else begin
          r0_rdata <= mem_data;
        end
      end
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_err <= 1'b0;
    end
  end

endmodule
